// File: rtl/dmem_lsu_ctrl_pkg.sv
// Shared types and constants for the data-memory load/store sequencer.
// The optional misalignment trap is selected with DMEM_LSU_MISALIGN_TRAP_EN.
package dmem_lsu_ctrl_pkg;

    localparam int WORD_LEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_RESP = 2'b01,
        LSU_RMW  = 2'b10
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } lsu_size_e;

    // Unlisted funct3 codes fall through to word access.
    function automatic lsu_size_e f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_B;
            F3_H, F3_HU: return SZ_H;
            default:     return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/dmem_store_merge.sv
// Combinational byte/half/word lane merge of store data into an old memory word.
// Word size passes the store data straight through.
module dmem_store_merge
    import dmem_lsu_ctrl_pkg::*;
(
    input  logic [WORD_LEN-1:0] i_old,
    input  logic [WORD_LEN-1:0] i_data,
    input  lsu_size_e           i_size,
    input  logic [1:0]          i_lo,
    output logic [WORD_LEN-1:0] o_word
);

    always_comb begin
        o_word = i_old;
        case (i_size)
            SZ_B: begin
                case (i_lo)
                    2'd0:    o_word[7:0]   = i_data[7:0];
                    2'd1:    o_word[15:8]  = i_data[7:0];
                    2'd2:    o_word[23:16] = i_data[7:0];
                    default: o_word[31:24] = i_data[7:0];
                endcase
            end
            SZ_H: begin
                if (i_lo[1]) o_word[31:16] = i_data[15:0];
                else         o_word[15:0]  = i_data[15:0];
            end
            default: o_word = i_data;
        endcase
    end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer for a word-only, 1-cycle-read-latency memory port.
// Define DMEM_LSU_MISALIGN_TRAP_EN to report misaligned/illegal requests on resp_err.
module dmem_lsu_ctrl
    import dmem_lsu_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [2:0]          req_funct3,
    input  logic [WORD_LEN-1:0] req_addr,
    input  logic [WORD_LEN-1:0] req_wdata,
    output logic                resp_valid,
    output logic [WORD_LEN-1:0] resp_rdata,
    output logic                resp_err,
    output logic [WORD_LEN-1:0] mem_addr,
    output logic                mem_wen,
    output logic [WORD_LEN-1:0] mem_wdata,
    input  logic [WORD_LEN-1:0] mem_rdata
);

    lsu_state_e          r_state;
    logic [WORD_LEN-1:0] r_addr;
    logic [WORD_LEN-1:0] r_wdata;
    logic [2:0]          r_f3;
    logic                r_wen;
    logic                r_err;

    logic                w_accept;
    logic                w_err;
    logic                w_sw;
    logic                w_rmw;
    logic                w_in_rmw;
    logic                w_uns;
    lsu_size_e           w_size;
    lsu_size_e           w_r_size;
    logic [WORD_LEN-1:0] w_merged;
    logic [WORD_LEN-1:0] w_load;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;

    assign req_ready = ((r_state == LSU_IDLE) || (r_state == LSU_RESP)) && !rst;
    assign w_accept  = req_valid && req_ready;
    assign w_in_rmw  = (r_state == LSU_RMW);
    assign w_size    = f3_size(req_funct3);
    assign w_r_size  = f3_size(r_f3);

`ifdef DMEM_LSU_MISALIGN_TRAP_EN
    always_comb begin
        w_err = 1'b0;
        case (req_funct3)
            F3_B:    w_err = 1'b0;
            F3_H:    w_err = req_addr[0];
            F3_W:    w_err = |req_addr[1:0];
            F3_BU:   w_err = req_wen;
            F3_HU:   w_err = req_wen || req_addr[0];
            default: w_err = 1'b1;
        endcase
    end
`else
    assign w_err = 1'b0;
`endif

    assign w_sw  = req_wen && !w_err && (w_size == SZ_W);
    assign w_rmw = req_wen && !w_err && (w_size != SZ_W);

    // Outside RMW the merge unit only serves the SW pass-through.
    dmem_store_merge u_merge (
        .i_old  (w_in_rmw ? mem_rdata : '0),
        .i_data (w_in_rmw ? r_wdata : req_wdata),
        .i_size (w_in_rmw ? w_r_size : w_size),
        .i_lo   (w_in_rmw ? r_addr[1:0] : req_addr[1:0]),
        .o_word (w_merged)
    );

    assign mem_addr  = w_accept ? {req_addr[WORD_LEN-1:2], 2'b00}
                                : {r_addr[WORD_LEN-1:2], 2'b00};
    assign mem_wen   = !rst && (w_in_rmw || (w_accept && w_sw));
    assign mem_wdata = mem_wen ? w_merged : '0;

    assign w_uns = (r_f3 == F3_BU) || (r_f3 == F3_HU);

    always_comb begin
        case (r_addr[1:0])
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (w_r_size)
            SZ_B:    w_load = w_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            SZ_H:    w_load = w_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load = mem_rdata;
        endcase
    end

    assign resp_valid = !rst && (r_state == LSU_RESP);
    assign resp_err   = resp_valid && r_err;
    assign resp_rdata = (resp_valid && !r_wen && !r_err) ? w_load : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LSU_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_f3    <= '0;
            r_wen   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                LSU_IDLE, LSU_RESP: begin
                    if (w_accept) begin
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_f3    <= req_funct3;
                        r_wen   <= req_wen;
                        r_err   <= w_err;
                        r_state <= w_rmw ? LSU_RMW : LSU_RESP;
                    end else begin
                        r_state <= LSU_IDLE;
                    end
                end
                LSU_RMW: r_state <= LSU_RESP;
                default: r_state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Bench for dmem_lsu_ctrl: directed load/store vectors plus a random mix against a byte-array model.
// Honours DMEM_LSU_MISALIGN_TRAP_EN the same way the design does.
module tb_dmem_lsu_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] mem [0:63];
    logic        mem_init;
    logic [7:0]  refb [0:255];

    dmem_lsu_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wen    (mem_wen),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] init_word(input int i);
        if (i == 16) return 32'h8899AABB;
        return 32'hA5A5A5A5 ^ (32'(i) * 32'h01010101);
    endfunction

    // Word memory, 1-cycle read latency, old data on same-address read-during-write.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        end else if (mem_wen) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr[7:2]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req_valid  = v;
        req_wen    = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    task automatic dir_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] exp, input logic exp_err);
        drive(1'b1, 1'b0, f3, a, 32'h0);
        chk({tag, ".rdy"}, req_ready, 1);
        chk({tag, ".addr"}, mem_addr, {a[31:2], 2'b00});
        chk({tag, ".wen0"}, mem_wen, 0);
        idle();
        chk({tag, ".vld"}, resp_valid, 1);
        chk({tag, ".data"}, resp_rdata, exp);
        chk({tag, ".err"}, resp_err, exp_err);
        chk({tag, ".wen1"}, mem_wen, 0);
        idle();
        chk({tag, ".vld_off"}, resp_valid, 0);
    endtask

    function automatic int sz_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic err_of(input logic w, input logic [2:0] f3, input logic [7:0] a);
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
        case (f3)
            3'b000:  return 1'b0;
            3'b001:  return a[0];
            3'b010:  return |a[1:0];
            3'b100:  return w;
            3'b101:  return w | a[0];
            default: return 1'b1;
        endcase
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        int          ops;
        int          cyc;
        int          s;
        logic        cur_rmw, rmw_next, cur_resp, resp_next, resp_next2;
        logic        rv, rw, e, acc, st_now;
        logic [2:0]  rf3;
        logic [7:0]  a8, base;
        logic [31:0] rd, exp_rd, ld;
        logic        exp_er;

        rst = 1'b1;
        mem_init = 1'b1;
        req_valid = 1'b0; req_wen = 1'b0; req_funct3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst.rdy", req_ready, 0);
        chk("rst.vld", resp_valid, 0);
        chk("rst.wen", mem_wen, 0);

        @(negedge clk);
        rst = 1'b0;
        mem_init = 1'b0;
        #1;
        chk("rv.rdy", req_ready, 1);
        chk("rv.vld", resp_valid, 0);
        chk("rv.rdata", resp_rdata, 32'h0);
        chk("rv.err", resp_err, 0);
        chk("rv.wen", mem_wen, 0);
        chk("rv.addr", mem_addr, 32'h0);
        chk("rv.wdata", mem_wdata, 32'h0);

        dir_load("lb41", 3'b000, 32'h41, 32'hFFFFFFAA, 1'b0);
        dir_load("lbu41", 3'b100, 32'h41, 32'h000000AA, 1'b0);
        dir_load("lh42", 3'b001, 32'h42, 32'hFFFF8899, 1'b0);
        dir_load("lhu40", 3'b101, 32'h40, 32'h0000AABB, 1'b0);

        // SB 0x43: read in accept cycle, write one cycle later, response one after that
        drive(1'b1, 1'b1, 3'b000, 32'h43, 32'h00000012);
        chk("sb.rdy", req_ready, 1);
        chk("sb.wen_n", mem_wen, 0);
        idle();
        chk("sb.rmw_rdy", req_ready, 0);
        chk("sb.wen_n1", mem_wen, 1);
        chk("sb.wdata", mem_wdata, 32'h1299AABB);
        chk("sb.waddr", mem_addr, 32'h40);
        chk("sb.vld_n1", resp_valid, 0);
        idle();
        chk("sb.vld_n2", resp_valid, 1);
        chk("sb.rdata", resp_rdata, 32'h0);
        chk("sb.wen_n2", mem_wen, 0);
        chk("sb.mem", mem[16], 32'h1299AABB);

        // SW then LW accepted in the SW response cycle
        drive(1'b1, 1'b1, 3'b010, 32'h44, 32'hDEADBEEF);
        chk("sw.wen", mem_wen, 1);
        chk("sw.wdata", mem_wdata, 32'hDEADBEEF);
        chk("sw.addr", mem_addr, 32'h44);
        drive(1'b1, 1'b0, 3'b010, 32'h44, 32'h0);
        chk("sw.vld", resp_valid, 1);
        chk("lw.rdy_b2b", req_ready, 1);
        chk("lw.wen", mem_wen, 0);
        idle();
        chk("lw.vld", resp_valid, 1);
        chk("lw.data", resp_rdata, 32'hDEADBEEF);
        idle();
        chk("lw.vld_off", resp_valid, 0);

        // Reset during the RMW cycle of SH 0x40 must suppress the write
        drive(1'b1, 1'b1, 3'b001, 32'h40, 32'h00005555);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("shr.wen", mem_wen, 0);
        chk("shr.vld", resp_valid, 0);
        chk("shr.rdy", req_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("shr.rdy_after", req_ready, 1);
        chk("shr.vld_after", resp_valid, 0);
        chk("shr.wen_after", mem_wen, 0);
        chk("shr.mem", mem[16], 32'h1299AABB);

`ifdef DMEM_LSU_MISALIGN_TRAP_EN
        dir_load("lw42", 3'b010, 32'h42, 32'h0, 1'b1);
        drive(1'b1, 1'b1, 3'b010, 32'h45, 32'h11223344);
        chk("swmis.wen", mem_wen, 0);
        idle();
        chk("swmis.err", resp_err, 1);
        chk("swmis.mem", mem[17], 32'hDEADBEEF);
`else
        dir_load("lw42", 3'b010, 32'h42, 32'h1299AABB, 1'b0);
`endif

        idle();
        for (int i = 0; i < 64; i++) begin
            for (int k = 0; k < 4; k++) refb[4 * i + k] = mem[i][8 * k +: 8];
        end

        ops = 0; cyc = 0;
        rmw_next = 1'b0; resp_next = 1'b0; resp_next2 = 1'b0;
        exp_rd = 32'h0; exp_er = 1'b0;
        while ((ops < 10000 || rmw_next || resp_next || resp_next2) && cyc < 40000) begin
            cur_rmw    = rmw_next;
            rmw_next   = 1'b0;
            cur_resp   = resp_next;
            resp_next  = resp_next2;
            resp_next2 = 1'b0;

            rv = (ops < 10000) && ($urandom_range(0, 3) != 0);
            rw = 1'($urandom_range(0, 1));
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
            rf3 = 3'($urandom_range(0, 7));
`else
            rf3 = rw ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
`endif
            a8 = 8'($urandom_range(0, 255));
            rd = $urandom;
            drive(rv, rw, rf3, {24'h0, a8}, rd);
            cyc++;

            chk("r.rdy", req_ready, !cur_rmw);
            chk("r.vld", resp_valid, cur_resp);
            if (cur_resp) begin
                chk("r.data", resp_rdata, exp_rd);
                chk("r.err", resp_err, exp_er);
            end

            acc = rv && !cur_rmw;
            s = sz_of(rf3);
            e = err_of(rw, rf3, a8);
            st_now = acc && rw && !e && (s == 4);
            chk("r.wen", mem_wen, cur_rmw || st_now);
            if (st_now) chk("r.wdata", mem_wdata, rd);

            if (acc) begin
                ops++;
                chk("r.addr", mem_addr, {24'h0, a8[7:2], 2'b00});
                base = (s == 4) ? {a8[7:2], 2'b00} : (s == 2) ? {a8[7:1], 1'b0} : a8;
                if (e) begin
                    exp_rd = 32'h0; exp_er = 1'b1; resp_next = 1'b1;
                end else if (rw) begin
                    for (int k = 0; k < s; k++) refb[int'(base) + k] = rd[8 * k +: 8];
                    exp_rd = 32'h0; exp_er = 1'b0;
                    if (s == 4) resp_next = 1'b1;
                    else begin rmw_next = 1'b1; resp_next2 = 1'b1; end
                end else begin
                    if (s == 1)
                        ld = {{24{refb[base][7] & ~rf3[2]}}, refb[base]};
                    else if (s == 2)
                        ld = {{16{refb[base + 8'd1][7] & ~rf3[2]}}, refb[base + 8'd1], refb[base]};
                    else
                        ld = {refb[base + 8'd3], refb[base + 8'd2], refb[base + 8'd1], refb[base]};
                    exp_rd = ld; exp_er = 1'b0; resp_next = 1'b1;
                end
            end
        end
        if (cyc >= 40000) begin
            n_total++;
            n_bad++;
            $display("FAIL r.timeout ops=%0d required=10000", ops);
        end

        idle();
        for (int i = 0; i < 64; i++) begin
            chk("r.mem", mem[i], {refb[4 * i + 3], refb[4 * i + 2], refb[4 * i + 1], refb[4 * i]});
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
